// File: rtl/alu_result_stage.sv
// ALU result stage: captures a single- or double-width ALU result and streams it to the
// CPU bus as one or two DATA_W beats, keeping HI/LO and zero/negative flags of the last result.
module alu_result_stage #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  clr_n,
  input  logic                  in_valid,
  input  logic                  in_wide,
  input  logic [2*DATA_W-1:0]   C,
  output logic                  in_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic [DATA_W-1:0]     hi_q,
  output logic [DATA_W-1:0]     lo_q,
  output logic                  flag_z,
  output logic                  flag_n,
  output logic [1:0]            dbg_state_o
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
  // Input side accepts only in IDLE; a result offered while busy is dropped, not queued.
  // Output side holds out_data/out_last and keeps out_valid high until out_ready.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND_LO = 2'd1,
    SEND_HI = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [2*DATA_W-1:0]   c_q, c_d;
  logic                  wide_q, wide_d;
  logic [DATA_W-1:0]     hi_d, lo_d;
  logic                  flag_z_d, flag_n_d;
  logic                  capture;
  logic                  beat_done;

  assign capture   = in_valid && in_ready;
  assign beat_done = out_valid && out_ready;

  // State register
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (capture)   state_d = SEND_LO;
      SEND_LO: if (beat_done) state_d = wide_q ? SEND_HI : IDLE;
      SEND_HI: if (beat_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic, purely from state and the registered result
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
      end
      SEND_LO: begin
        out_valid = 1'b1;
        out_last  = !wide_q;
        out_data  = c_q[DATA_W-1:0];
      end
      SEND_HI: begin
        out_valid = 1'b1;
        out_last  = 1'b1;
        out_data  = c_q[2*DATA_W-1:DATA_W];
      end
      default: ;
    endcase
  end

  assign dbg_state_o = state_q;

  // Datapath next values; the upper half of C never influences a narrow result
  always_comb begin
    c_d      = c_q;
    wide_d   = wide_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    flag_z_d = flag_z;
    flag_n_d = flag_n;
    if (capture) begin
      c_d    = C;
      wide_d = in_wide;
      if (in_wide) begin
        hi_d     = C[2*DATA_W-1:DATA_W];
        lo_d     = C[DATA_W-1:0];
        flag_z_d = ~|C;
        flag_n_d = C[2*DATA_W-1];
      end else begin
        flag_z_d = ~|C[DATA_W-1:0];
        flag_n_d = C[DATA_W-1];
      end
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      c_q    <= '0;
      wide_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      flag_z <= 1'b0;
      flag_n <= 1'b0;
    end else begin
      c_q    <= c_d;
      wide_q <= wide_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      flag_z <= flag_z_d;
      flag_n <= flag_n_d;
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: table of single results with hand-computed beats
// and flags, plus sequences for backpressure, busy drop and reset mid-transfer.
module tb_alu_result_stage;

  localparam int W = 32;

  logic            clk;
  logic            clr_n;
  logic            in_valid;
  logic            in_wide;
  logic [2*W-1:0]  c;
  logic            in_ready;
  logic [W-1:0]    out_data;
  logic            out_valid;
  logic            out_ready;
  logic            out_last;
  logic [W-1:0]    hi_q;
  logic [W-1:0]    lo_q;
  logic            flag_z;
  logic            flag_n;
  logic [1:0]      dbg_state;

  int checks = 0;
  int errors = 0;

  alu_result_stage #(.DATA_W(W)) dut (
    .clk         (clk),
    .clr_n       (clr_n),
    .in_valid    (in_valid),
    .in_wide     (in_wide),
    .C           (c),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .hi_q        (hi_q),
    .lo_q        (lo_q),
    .flag_z      (flag_z),
    .flag_n      (flag_n),
    .dbg_state_o (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2*W-1:0] c;
    logic           wide;
    logic [W-1:0]   e_lo;
    logic [W-1:0]   e_hi;
    logic           e_z;
    logic           e_n;
    logic [W-1:0]   e_hiq;
    logic [W-1:0]   e_loq;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".in_ready"},  64'(in_ready),  64'd1);
    chk({tag, ".out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, ".out_last"},  64'(out_last),  64'd0);
    chk({tag, ".out_data"},  64'(out_data),  64'd0);
  endtask

  // Offer one result at a negedge with out_ready=1 and check every beat and the flags.
  task automatic run_vec(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("vec%0d", idx);
    chk({tag, ".pre_ready"}, 64'(in_ready), 64'd1);
    c = v.c; in_wide = v.wide; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    c = '0;
    chk({tag, ".lo_valid"}, 64'(out_valid), 64'd1);
    chk({tag, ".lo_data"},  64'(out_data),  64'(v.e_lo));
    chk({tag, ".lo_last"},  64'(out_last),  64'(!v.wide));
    chk({tag, ".busy"},     64'(in_ready),  64'd0);
    chk({tag, ".flag_z"},   64'(flag_z),    64'(v.e_z));
    chk({tag, ".flag_n"},   64'(flag_n),    64'(v.e_n));
    chk({tag, ".hi_q"},     64'(hi_q),      64'(v.e_hiq));
    chk({tag, ".lo_q"},     64'(lo_q),      64'(v.e_loq));
    if (v.wide) begin
      step();
      chk({tag, ".hi_valid"}, 64'(out_valid), 64'd1);
      chk({tag, ".hi_data"},  64'(out_data),  64'(v.e_hi));
      chk({tag, ".hi_last"},  64'(out_last),  64'd1);
    end
    step();
    chk_idle({tag, ".end"});
  endtask

  initial begin
    //            c                         wide e_lo          e_hi          z     n     hiq           loq
    vecs[0] = '{64'h0000_0000_0000_0005, 1'b0, 32'h0000_0005, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0};
    vecs[1] = '{64'h0000_0001_0000_0002, 1'b1, 32'h0000_0002, 32'h0000_0001, 1'b0, 1'b0, 32'h1,        32'h2};
    vecs[2] = '{64'hFFFF_FFFF_0000_0000, 1'b0, 32'h0000_0000, 32'h0,        1'b1, 1'b0, 32'h1,        32'h2};
    vecs[3] = '{64'h0000_0000_8000_0000, 1'b0, 32'h8000_0000, 32'h0,        1'b0, 1'b1, 32'h1,        32'h2};
    vecs[4] = '{64'h0000_0000_0000_0000, 1'b1, 32'h0000_0000, 32'h0,        1'b1, 1'b0, 32'h0,        32'h0};
    vecs[5] = '{64'h8000_0000_0000_0000, 1'b1, 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b1, 32'h8000_0000, 32'h0};
    vecs[6] = '{64'h1234_5678_9ABC_DEF0, 1'b1, 32'h9ABC_DEF0, 32'h1234_5678, 1'b0, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0};
    vecs[7] = '{64'hDEAD_BEEF_0000_0001, 1'b0, 32'h0000_0001, 32'h0,        1'b0, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0};

    // Reset
    clr_n = 1'b0; in_valid = 1'b0; in_wide = 1'b0; c = '0; out_ready = 1'b0;
    #1;
    chk_idle("reset");
    chk("reset.hi_q",   64'(hi_q),   64'd0);
    chk("reset.lo_q",   64'(lo_q),   64'd0);
    chk("reset.flag_z", 64'(flag_z), 64'd0);
    chk("reset.flag_n", 64'(flag_n), 64'd0);
    @(negedge clk);
    @(negedge clk);
    clr_n = 1'b1;
    @(negedge clk);

    // Table, back-to-back with the minimum single IDLE cycle
    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Backpressure: hold LO beat for 3 cycles
    c = 64'hAAAA_0000_BBBB_0001; in_wide = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("bp.hold%0d.valid", k), 64'(out_valid), 64'd1);
      chk($sformatf("bp.hold%0d.data", k),  64'(out_data),  64'hBBBB_0001);
      chk($sformatf("bp.hold%0d.last", k),  64'(out_last),  64'd0);
      if (k < 2) step();
    end
    out_ready = 1'b1;
    step();
    chk("bp.hi_data", 64'(out_data), 64'hAAAA_0000);
    chk("bp.hi_last", 64'(out_last), 64'd1);
    step();
    chk_idle("bp.end");
    chk("bp.hi_q", 64'(hi_q), 64'hAAAA_0000);
    chk("bp.lo_q", 64'(lo_q), 64'hBBBB_0001);

    // Busy drop: narrow C=7 offered during SEND_HI
    c = 64'h0000_0003_0000_0004; in_wide = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    chk("drop.in_hi", 64'(out_data), 64'h3);
    c = 64'h7; in_wide = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk_idle("drop.after");
    step();
    chk_idle("drop.no_extra");
    chk("drop.flag_z", 64'(flag_z), 64'd0);
    chk("drop.flag_n", 64'(flag_n), 64'd0);
    chk("drop.lo_q",   64'(lo_q),   64'h4);

    // Reset mid-transfer, asserted in SEND_HI away from the clock edge
    c = 64'h0000_0009_0000_000A; in_wide = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    chk("rst.pre_data", 64'(out_data), 64'h9);
    #2 clr_n = 1'b0;
    #1;
    chk_idle("rst.async");
    chk("rst.hi_q", 64'(hi_q), 64'd0);
    chk("rst.lo_q", 64'(lo_q), 64'd0);
    @(negedge clk);
    clr_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_idle($sformatf("rst.post%0d", k));
    end

    // First capture straight after reset release
    run_vec(8, '{64'h0000_0000_FFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1, 32'h0, 32'h0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
